// File: rtl/moore_10x0_seq_gen_pkg.sv
// State encodings and frame constants shared by the 10X0 generator and detector.
// Keep encodings stable: the detector decodes the same values.
package moore_10x0_seq_gen_pkg;

    localparam int STATE_W = 3;

    typedef logic [STATE_W-1:0] state_t;

    localparam logic [2:0] IDLE  = 3'd0;
    localparam logic [2:0] G1    = 3'd1;
    localparam logic [2:0] G10   = 3'd2;
    localparam logic [2:0] G10X  = 3'd3;
    localparam logic [2:0] G10X0 = 3'd4;

    localparam int FRAME_LEN = 4;
    localparam int OVL_LEN   = 2;

endpackage

// File: rtl/moore_10x0_seq_gen_frame_counter.sv
// Wrapping completed-frame counter with async active-low clear.
// Latency: count visible the cycle after inc_i; no backpressure.
// Backpressure: none, increments whenever enabled.
module seq_frame_counter #(
    parameter int CNT_W = 8
) (
    input  logic             Clk,
    input  logic             Rst,
    input  logic             inc_i,
    output logic [CNT_W-1:0] cnt_o
);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    assign cnt_d = cnt_q + CNT_W'(1);

    always_ff @(posedge Clk or negedge Rst) begin
        if (!Rst) begin
            cnt_q <= '0;
        end else if (inc_i) begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt_o = cnt_q;

endmodule

// File: rtl/moore_10x0_seq_gen.sv
// Moore serializer of 1,0,X,0 frames, optionally overlapping a 1010 tail into the next frame.
// Latency: first bit driven the cycle after accept; frames run back-to-back without gaps.
// Backpressure: Ready only in IDLE and on the last bit; requester holds Valid/X until accepted.
module moore_10x0_seq_gen
    import moore_10x0_seq_gen_pkg::*;
#(
    parameter bit OVERLAP = 1'b1,
    parameter int CNT_W   = 8
) (
    input  logic             Clk,
    input  logic             Rst,
    input  logic             Valid,
    input  logic             X,
    output logic             Ready,
    output logic             OP,
    output logic             Busy,
    output logic             Done,
    output logic [CNT_W-1:0] FrameCnt,
    output logic [2:0]       CS,
    output logic [2:0]       NS
);

    state_t cs_q;
    state_t ns_d;
    logic   x_q;
    logic   op_d;
    logic   accept;

    assign Ready  = (cs_q == IDLE) || (cs_q == G10X0);
    assign accept = Valid & Ready;

    always_comb begin
        ns_d = IDLE;
        case (cs_q)
            IDLE:    ns_d = accept ? G1 : IDLE;
            G1:      ns_d = G10;
            G10:     ns_d = G10X;
            G10X:    ns_d = G10X0;
            // x_q still holds the outgoing frame's bit here, so it decides overlap.
            G10X0:   ns_d = accept ? ((OVERLAP && x_q) ? G10X : G1) : IDLE;
            default: ns_d = IDLE;
        endcase
    end

    always_comb begin
        op_d = 1'b0;
        case (cs_q)
            G1:      op_d = 1'b1;
            G10X:    op_d = x_q;
            default: op_d = 1'b0;
        endcase
    end

    always_ff @(posedge Clk or negedge Rst) begin
        if (!Rst) begin
            cs_q <= IDLE;
            x_q  <= 1'b0;
        end else begin
            cs_q <= ns_d;
            if (accept) begin
                x_q <= X;
            end
        end
    end

    // G10X0 always lasts one cycle, so its presence marks the completing edge.
    seq_frame_counter #(
        .CNT_W (CNT_W)
    ) u_frame_cnt (
        .Clk   (Clk),
        .Rst   (Rst),
        .inc_i (Done),
        .cnt_o (FrameCnt)
    );

    assign OP   = op_d;
    assign Busy = (cs_q != IDLE);
    assign Done = (cs_q == G10X0);
    assign CS   = cs_q;
    assign NS   = ns_d;

endmodule

// File: tb/tb_moore_10x0_seq_gen.sv
module tb_moore_10x0_seq_gen;

    typedef struct {
        logic       v;
        logic       x;
        logic [2:0] cs;
        logic       op;
        logic       rdy;
        logic       done;
        logic [7:0] cnt;
    } vec_t;

    logic       Clk;
    logic       rst_n [3];
    logic       vld   [3];
    logic       xi    [3];
    logic       rdy   [3];
    logic       op    [3];
    logic       busy  [3];
    logic       done  [3];
    logic [2:0] cs    [3];
    logic [2:0] ns    [3];
    logic [7:0] cnt0;
    logic [7:0] cnt1;
    logic [1:0] cnt2;

    int checks = 0;
    int errors = 0;

    vec_t tbl [40];
    int   n;

    moore_10x0_seq_gen #(.OVERLAP(1'b1), .CNT_W(8)) u_ovl (
        .Clk(Clk), .Rst(rst_n[0]), .Valid(vld[0]), .X(xi[0]), .Ready(rdy[0]), .OP(op[0]),
        .Busy(busy[0]), .Done(done[0]), .FrameCnt(cnt0), .CS(cs[0]), .NS(ns[0]));

    moore_10x0_seq_gen #(.OVERLAP(1'b0), .CNT_W(8)) u_novl (
        .Clk(Clk), .Rst(rst_n[1]), .Valid(vld[1]), .X(xi[1]), .Ready(rdy[1]), .OP(op[1]),
        .Busy(busy[1]), .Done(done[1]), .FrameCnt(cnt1), .CS(cs[1]), .NS(ns[1]));

    moore_10x0_seq_gen #(.OVERLAP(1'b1), .CNT_W(2)) u_c2 (
        .Clk(Clk), .Rst(rst_n[2]), .Valid(vld[2]), .X(xi[2]), .Ready(rdy[2]), .OP(op[2]),
        .Busy(busy[2]), .Done(done[2]), .FrameCnt(cnt2), .CS(cs[2]), .NS(ns[2]));

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int cnt_of(input int d);
        case (d)
            0:       return int'(cnt0);
            1:       return int'(cnt1);
            default: return int'(cnt2);
        endcase
    endfunction

    function automatic vec_t mk(input int v, input int x, input int s, input int o,
                                input int r, input int dn, input int c);
        vec_t t;
        t.v    = v[0];
        t.x    = x[0];
        t.cs   = s[2:0];
        t.op   = o[0];
        t.rdy  = r[0];
        t.done = dn[0];
        t.cnt  = c[7:0];
        return t;
    endfunction

    task automatic add(input int v, input int x, input int s, input int o,
                       input int r, input int dn, input int c);
        tbl[n] = mk(v, x, s, o, r, dn, c);
        n++;
    endtask

    task automatic run_table(input int d, input string tag);
        for (int i = 0; i < n; i++) begin
            @(negedge Clk);
            vld[d] = tbl[i].v;
            xi[d]  = tbl[i].x;
            #1;
            chk($sformatf("%s[%0d].cs", tag, i),   int'(cs[d]),   int'(tbl[i].cs));
            chk($sformatf("%s[%0d].op", tag, i),   int'(op[d]),   int'(tbl[i].op));
            chk($sformatf("%s[%0d].rdy", tag, i),  int'(rdy[d]),  int'(tbl[i].rdy));
            chk($sformatf("%s[%0d].done", tag, i), int'(done[d]), int'(tbl[i].done));
            chk($sformatf("%s[%0d].busy", tag, i), int'(busy[d]), int'(tbl[i].cs != 3'd0));
            chk($sformatf("%s[%0d].cnt", tag, i),  cnt_of(d),     int'(tbl[i].cnt));
            if (i + 1 < n)
                chk($sformatf("%s[%0d].ns", tag, i), int'(ns[d]), int'(tbl[i+1].cs));
        end
        vld[d] = 1'b0;
        xi[d]  = 1'b0;
    endtask

    initial begin
        int exp_c [5];
        exp_c = '{1, 2, 3, 0, 1};

        for (int d = 0; d < 3; d++) begin
            rst_n[d] = 1'b0;
            vld[d]   = 1'b0;
            xi[d]    = 1'b0;
        end
        repeat (2) @(negedge Clk);
        #1;
        for (int d = 0; d < 3; d++) begin
            chk($sformatf("rst%0d.op", d),   int'(op[d]),   0);
            chk($sformatf("rst%0d.rdy", d),  int'(rdy[d]),  1);
            chk($sformatf("rst%0d.busy", d), int'(busy[d]), 0);
            chk($sformatf("rst%0d.done", d), int'(done[d]), 0);
            chk($sformatf("rst%0d.cs", d),   int'(cs[d]),   0);
            chk($sformatf("rst%0d.cnt", d),  cnt_of(d),     0);
        end
        @(negedge Clk);
        for (int d = 0; d < 3; d++) rst_n[d] = 1'b1;

        // Overlap-enabled instance: single frames, overlapped 1010->X=0, and 1000->1010.
        n = 0;
        add(1,1,0,0,1,0,0); add(0,0,1,1,0,0,0); add(0,0,2,0,0,0,0); add(0,0,3,1,0,0,0);
        add(0,0,4,0,1,1,0); add(0,0,0,0,1,0,1);
        add(1,0,0,0,1,0,1); add(0,0,1,1,0,0,1); add(0,0,2,0,0,0,1); add(0,0,3,0,0,0,1);
        add(0,0,4,0,1,1,1); add(0,0,0,0,1,0,2);
        add(1,1,0,0,1,0,2); add(1,0,1,1,0,0,2); add(1,0,2,0,0,0,2); add(1,0,3,1,0,0,2);
        add(1,0,4,0,1,1,2); add(0,0,3,0,0,0,3); add(0,0,4,0,1,1,3); add(0,0,0,0,1,0,4);
        add(1,0,0,0,1,0,4); add(1,1,1,1,0,0,4); add(1,0,2,0,0,0,4); add(1,1,3,0,0,0,4);
        add(1,1,4,0,1,1,4); add(0,0,1,1,0,0,5); add(0,0,2,0,0,0,5); add(0,0,3,1,0,0,5);
        add(0,0,4,0,1,1,5); add(0,0,0,0,1,0,6);
        run_table(0, "ovl");

        // Overlap-disabled instance: 1010 followed by 1000 sends all eight bits.
        n = 0;
        add(1,1,0,0,1,0,0); add(1,0,1,1,0,0,0); add(1,0,2,0,0,0,0); add(1,0,3,1,0,0,0);
        add(1,0,4,0,1,1,0); add(0,0,1,1,0,0,1); add(0,0,2,0,0,0,1); add(0,0,3,0,0,0,1);
        add(0,0,4,0,1,1,1); add(0,0,0,0,1,0,2);
        run_table(1, "novl");

        // Reset pulsed while in G10 aborts the frame immediately.
        @(negedge Clk);
        vld[0] = 1'b1; xi[0] = 1'b1;
        @(negedge Clk);
        vld[0] = 1'b0; xi[0] = 1'b0;
        #1 chk("abort.g1", int'(cs[0]), 1);
        @(negedge Clk);
        #1 chk("abort.g10", int'(cs[0]), 2);
        #2 rst_n[0] = 1'b0;
        #1;
        chk("abort.cs",   int'(cs[0]),   0);
        chk("abort.op",   int'(op[0]),   0);
        chk("abort.cnt",  cnt_of(0),     0);
        chk("abort.rdy",  int'(rdy[0]),  1);
        chk("abort.busy", int'(busy[0]), 0);
        @(negedge Clk);
        rst_n[0] = 1'b1;
        repeat (3) @(negedge Clk);
        #1;
        chk("abort.stay_cs",  int'(cs[0]), 0);
        chk("abort.stay_op",  int'(op[0]), 0);
        chk("abort.stay_cnt", cnt_of(0),   0);

        // 2-bit counter wraps over five back-to-back frames.
        @(negedge Clk);
        vld[2] = 1'b1; xi[2] = 1'b0;
        for (int f = 0; f < 5; f++) begin
            repeat ((f == 0) ? 4 : 3) @(negedge Clk);
            #1;
            chk($sformatf("wrap%0d.done", f), int'(done[2]), 1);
            vld[2] = (f < 4);
            @(negedge Clk);
            #1;
            chk($sformatf("wrap%0d.cnt", f), cnt_of(2), exp_c[f]);
            chk($sformatf("wrap%0d.cs", f), int'(cs[2]), (f < 4) ? 1 : 0);
        end

        // Illegal state code returns to IDLE on the next edge.
        @(negedge Clk);
        force u_c2.cs_q = 3'd6;
        #1;
        chk("ill.cs",  int'(cs[2]),  6);
        chk("ill.op",  int'(op[2]),  0);
        chk("ill.ns",  int'(ns[2]),  0);
        chk("ill.rdy", int'(rdy[2]), 0);
        release u_c2.cs_q;
        @(negedge Clk);
        #1;
        chk("ill.next_cs", int'(cs[2]), 0);
        chk("ill.next_op", int'(op[2]), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
